// File: rtl/init_reset_sequencer.sv
// ----------------------------------------------------------------------------
// init_reset_sequencer
//
// Purpose:
//   Holds the user fabric in reset until the device is fully up. The fabric
//   reset is released only after each of these conditions has been seen, in
//   this order:
//     1. power-on reset has been released,
//     2. device initialisation has completed,
//     3. all three I/O banks have calibrated,
//     4. the fabric PLL has locked.
//   After that, the reset is held low for a further HOLD_CYCLES clocks.
//   All condition inputs are asynchronous, so each one goes through a
//   two-flop synchronizer before the FSM uses it. Loss of PLL lock sends the
//   sequence back to waiting for lock. Loss of power-on reset sends it all the
//   way back to the start.
//
// Parameters:
//   HOLD_CYCLES     cycles the fabric reset stays low once all conditions
//                   are met (1..255)
//   TIMEOUT_CYCLES  calibration watchdog limit (1..2^20-1). This parameter
//                   exists only with INIT_RESET_SEQ_TIMEOUT_EN defined.
//
// Ports:
//   clk_i                clock for all sequential logic
//   resetn_i             asynchronous active-low reset
//   fabric_por_n_i       power-on-reset release (async)
//   device_init_done_i   device initialisation complete (async)
//   bank_calib_status_i  calibration done for banks 7/8/9 on bits 0/1/2 (async)
//   pll_lock_i           fabric PLL lock (async)
//   fabric_reset_n_o     registered active-low reset to the user fabric
//   seq_done_o           high only while the FSM is in RUN
//   state_o              current state code
//   calib_timeout_o      sticky calibration watchdog flag
//                        (this port exists only with the macro defined)
//
// Configuration macro:
//   INIT_RESET_SEQ_TIMEOUT_EN  adds the 20-bit calibration watchdog, the
//                              TIMEOUT_CYCLES parameter and calib_timeout_o.
// ----------------------------------------------------------------------------
module init_reset_sequencer #(
    parameter int unsigned HOLD_CYCLES = 16
`ifdef INIT_RESET_SEQ_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic       clk_i,
    input  logic       resetn_i,
    input  logic       fabric_por_n_i,
    input  logic       device_init_done_i,
    input  logic [2:0] bank_calib_status_i,
    input  logic       pll_lock_i,
    output logic       fabric_reset_n_o,
    output logic       seq_done_o,
    output logic [2:0] state_o
`ifdef INIT_RESET_SEQ_TIMEOUT_EN
    ,
    output logic       calib_timeout_o
`endif
);

    typedef enum logic [2:0] {
        ST_WAIT_POR   = 3'd0,
        ST_WAIT_INIT  = 3'd1,
        ST_WAIT_CALIB = 3'd2,
        ST_WAIT_LOCK  = 3'd3,
        ST_HOLD       = 3'd4,
        ST_RUN        = 3'd5
    } state_e;

    // Value of the hold counter on the last cycle spent in HOLD.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    // Bundle the asynchronous inputs so one synchronizer covers them all.
    // Layout: [5] pll_lock, [4:2] bank calib, [1] init done, [0] por.
    logic [5:0] async_s;
    logic [5:0] sync_meta_q;
    logic [5:0] sync_q;
    logic       por_s;
    logic       init_s;
    logic [2:0] calib_s;
    logic       lock_s;

    assign async_s = {pll_lock_i, bank_calib_status_i, device_init_done_i, fabric_por_n_i};
    assign por_s   = sync_q[0];
    assign init_s  = sync_q[1];
    assign calib_s = sync_q[4:2];
    assign lock_s  = sync_q[5];

    // Two-flop synchronizer for every asynchronous condition input.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            sync_meta_q <= 6'b000000;
            sync_q      <= 6'b000000;
        end else begin
            sync_meta_q <= async_s;
            sync_q      <= sync_meta_q;
        end
    end

    state_e     state_q;
    state_e     state_d;
    logic [7:0] hold_cnt_q;
    logic [7:0] hold_cnt_d;
    logic       fabric_reset_n_q;
    logic       seq_done_q;

    // Next-state logic and hold counter. Loss of POR overrides everything.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        if (!por_s) begin
            state_d    = ST_WAIT_POR;
            hold_cnt_d = 8'd0;
        end else begin
            case (state_q)
                ST_WAIT_POR: begin
                    // Reaching this branch means the synced POR is already high.
                    state_d = ST_WAIT_INIT;
                end
                ST_WAIT_INIT: begin
                    if (init_s) begin
                        state_d = ST_WAIT_CALIB;
                    end else begin
                        state_d = ST_WAIT_INIT;
                    end
                end
                ST_WAIT_CALIB: begin
                    if (calib_s == 3'b111) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        state_d = ST_WAIT_CALIB;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = 8'd0;
                    end else begin
                        state_d = ST_WAIT_LOCK;
                    end
                end
                ST_HOLD: begin
                    // The counter saturates instead of wrapping.
                    if (hold_cnt_q != 8'hFF) begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end else begin
                        hold_cnt_d = hold_cnt_q;
                    end
                    // Losing lock on the final hold cycle still aborts the hold.
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    // Codes 6 and 7 should never occur; recover to the start.
                    state_d    = ST_WAIT_POR;
                    hold_cnt_d = 8'd0;
                end
            endcase
        end
    end

    // State register, hold counter and registered outputs.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q          <= ST_WAIT_POR;
            hold_cnt_q       <= 8'd0;
            fabric_reset_n_q <= 1'b0;
            seq_done_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            hold_cnt_q       <= hold_cnt_d;
            // Follows the state register, so the fabric reset lags RUN
            // entry and exit by exactly one cycle.
            fabric_reset_n_q <= (state_q == ST_RUN);
            seq_done_q       <= (state_d == ST_RUN);
        end
    end

    assign fabric_reset_n_o = fabric_reset_n_q;
    assign seq_done_o       = seq_done_q;
    assign state_o          = state_q;

`ifdef INIT_RESET_SEQ_TIMEOUT_EN
    localparam logic [19:0] TIMEOUT_VAL = 20'(TIMEOUT_CYCLES);

    logic [19:0] wd_cnt_q;
    logic [19:0] wd_cnt_d;
    logic        calib_timeout_q;
    logic        calib_timeout_d;

    // Watchdog: the counter restarts on each entry to WAIT_CALIB and counts
    // while the FSM stays there. The flag is sticky until resetn_i.
    always_comb begin
        wd_cnt_d        = wd_cnt_q;
        calib_timeout_d = calib_timeout_q;
        if ((state_q != ST_WAIT_CALIB) && (state_d == ST_WAIT_CALIB)) begin
            wd_cnt_d = 20'd0;
        end else if ((state_q == ST_WAIT_CALIB) && (wd_cnt_q != 20'hFFFFF)) begin
            wd_cnt_d = wd_cnt_q + 20'd1;
        end else begin
            wd_cnt_d = wd_cnt_q;
        end
        if (wd_cnt_d == TIMEOUT_VAL) begin
            calib_timeout_d = 1'b1;
        end else begin
            calib_timeout_d = calib_timeout_q;
        end
    end

    // Watchdog counter and sticky timeout flag registers.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wd_cnt_q        <= 20'd0;
            calib_timeout_q <= 1'b0;
        end else begin
            wd_cnt_q        <= wd_cnt_d;
            calib_timeout_q <= calib_timeout_d;
        end
    end

    assign calib_timeout_o = calib_timeout_q;
`endif

endmodule
